// File: rtl/mem_arbiter.sv
// mem_arbiter: two requester ports sharing one single-port synchronous memory.
// Round-robin arbitration, a single transaction in flight (IDLE -> BUSY -> RESP),
// and addresses at or beyond DEPTH are answered with an error instead of
// reaching the memory.
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic              clk_i,
    input  logic              srst_ni,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic              req0_we_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [DATA_W-1:0] req0_wdata_i,
    output logic              rsp0_valid_o,
    input  logic              rsp0_ready_i,
    output logic [DATA_W-1:0] rsp0_rdata_o,
    output logic              rsp0_err_o,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic              req1_we_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [DATA_W-1:0] req1_wdata_i,
    output logic              rsp1_valid_o,
    input  logic              rsp1_ready_i,
    output logic [DATA_W-1:0] rsp1_rdata_o,
    output logic              rsp1_err_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_srst_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Depth widened by one bit so the compare never truncates.
    localparam logic [32:0] DEPTH_L = 33'(DEPTH);

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic              last_r;      // port granted by the previous accept
    logic              gnt_r;       // port owning the transaction in flight
    logic              we_r;
    logic              err_r;
    logic [DATA_W-1:0] rsp_data_r;
    logic [ADDR_W-1:0] addr_r;      // last address actually issued to memory
    logic [DATA_W-1:0] wdata_r;

    logic              any_s;
    logic              win_s;
    logic              accept_s;
    logic              issue_s;
    logic              in_range_s;
    logic              win_we_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [DATA_W-1:0] win_wdata_s;
    logic              rsp_ready_s;

    // Arbitration: lone requester wins, a tie goes to the port not granted last.
    always_comb begin
        any_s = req0_valid_i | req1_valid_i;
        if (req0_valid_i && req1_valid_i) begin
            win_s = ~last_r;
        end else if (req1_valid_i) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
        if (win_s) begin
            win_we_s    = req1_we_i;
            win_addr_s  = req1_addr_i;
            win_wdata_s = req1_wdata_i;
        end else begin
            win_we_s    = req0_we_i;
            win_addr_s  = req0_addr_i;
            win_wdata_s = req0_wdata_i;
        end
        // Ready is held low while reset is asserted, so nothing is accepted then.
        accept_s     = srst_ni && (state_r == ST_IDLE) && any_s;
        req0_ready_o = accept_s && !win_s;
        req1_ready_o = accept_s && win_s;
        in_range_s   = (33'(win_addr_s) < DEPTH_L);
        issue_s      = accept_s && in_range_s;
    end

    // Memory command: driven from the winner in the accept cycle, otherwise parked.
    always_comb begin
        mem_srst_o = ~srst_ni;
        if (issue_s) begin
            mem_we_o    = win_we_s;
            mem_addr_o  = win_addr_s;
            mem_wdata_o = win_wdata_s;
        end else begin
            mem_we_o    = 1'b0;
            mem_addr_o  = addr_r;
            mem_wdata_o = wdata_r;
        end
    end

    // Next-state logic for the single-outstanding transaction FSM.
    always_comb begin
        rsp_ready_s = gnt_r ? rsp1_ready_i : rsp0_ready_i;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                state_nxt_s = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, transaction bookkeeping and response capture.
    always_ff @(posedge clk_i) begin
        if (!srst_ni) begin
            state_r    <= ST_IDLE;
            last_r     <= 1'b1;
            gnt_r      <= 1'b0;
            we_r       <= 1'b0;
            err_r      <= 1'b0;
            rsp_data_r <= '0;
            addr_r     <= '0;
            wdata_r    <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                last_r <= win_s;
                gnt_r  <= win_s;
                we_r   <= win_we_s;
                err_r  <= !in_range_s;
            end
            if (issue_s) begin
                addr_r  <= win_addr_s;
                wdata_r <= win_wdata_s;
            end
            // Memory read data is valid in BUSY, one cycle after issue.
            if (state_r == ST_BUSY) begin
                if (!we_r && !err_r) begin
                    rsp_data_r <= mem_rdata_i;
                end else begin
                    rsp_data_r <= '0;
                end
            end
        end
    end

    // Response outputs: only the owning port sees valid; payload is zero otherwise.
    always_comb begin
        rsp0_valid_o = (state_r == ST_RESP) && !gnt_r;
        rsp1_valid_o = (state_r == ST_RESP) && gnt_r;
        if (rsp0_valid_o) begin
            rsp0_rdata_o = rsp_data_r;
            rsp0_err_o   = err_r;
        end else begin
            rsp0_rdata_o = '0;
            rsp0_err_o   = 1'b0;
        end
        if (rsp1_valid_o) begin
            rsp1_rdata_o = rsp_data_r;
            rsp1_err_o   = err_r;
        end else begin
            rsp1_rdata_o = '0;
            rsp1_err_o   = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: behavioural memory, transaction-level reference
// model, directed scenarios followed by randomized traffic.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        srst_n;
    logic        req0_valid, req0_ready, req0_we, req1_valid, req1_ready, req1_we;
    logic [15:0] req0_addr, req1_addr;
    logic [31:0] req0_wdata, req1_wdata;
    logic        rsp0_valid, rsp0_ready, rsp0_err, rsp1_valid, rsp1_ready, rsp1_err;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic        mem_we, mem_srst;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [1:0]  rdy;
        logic        acc_we;
        logic [15:0] acc_addr;
        logic [31:0] acc_wdata;
        logic [7:0]  lat;
        logic [31:0] rdata;
        logic        err;
        logic        stable;
        logic        stray;
        logic        cleared;
        logic        tmo;
    } obs_t;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk_i(clk), .srst_ni(srst_n),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_we_i(req0_we),
        .req0_addr_i(req0_addr), .req0_wdata_i(req0_wdata),
        .rsp0_valid_o(rsp0_valid), .rsp0_ready_i(rsp0_ready),
        .rsp0_rdata_o(rsp0_rdata), .rsp0_err_o(rsp0_err),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_we_i(req1_we),
        .req1_addr_i(req1_addr), .req1_wdata_i(req1_wdata),
        .rsp1_valid_o(rsp1_valid), .rsp1_ready_i(rsp1_ready),
        .rsp1_rdata_o(rsp1_rdata), .rsp1_err_o(rsp1_err),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_srst_o(mem_srst), .mem_rdata_i(mem_rdata)
    );

    // Single-port synchronous memory, initialised to all ones, read port reset by mem_srst.
    logic [31:0] mem [0:1023];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hFFFF_FFFF;
    end
    always @(posedge clk) begin
        if (mem_srst) begin
            mem_rdata <= 32'h0;
        end else begin
            if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
            mem_rdata <= mem[mem_addr[9:0]];
        end
    end

    // Reference model: one call per accepted transaction.
    logic        model_last;
    logic [15:0] model_addr;
    logic [31:0] model_mem [0:1023];

    task automatic model_reset();
        model_last = 1'b1;
        model_addr = 16'h0;
    endtask

    task automatic model_txn(input logic v0, input logic we0, input logic [15:0] a0, input logic [31:0] d0,
                             input logic v1, input logic we1, input logic [15:0] a1, input logic [31:0] d1,
                             output logic [1:0] e_rdy, output logic e_we, output logic [15:0] e_addr,
                             output logic [31:0] e_wdata, output logic [31:0] e_rdata, output logic e_err);
        logic win, we;
        logic [15:0] a;
        logic [31:0] d;
        win = (v0 && v1) ? ~model_last : v1;
        model_last = win;
        e_rdy = win ? 2'b10 : 2'b01;
        we = win ? we1 : we0;
        a  = win ? a1 : a0;
        d  = win ? d1 : d0;
        e_wdata = d;
        if (a >= 16'd1024) begin
            e_err = 1'b1; e_rdata = 32'h0; e_we = 1'b0; e_addr = model_addr;
        end else begin
            e_err = 1'b0; e_we = we; e_addr = a; model_addr = a;
            if (we) begin
                model_mem[a[9:0]] = d;
                e_rdata = 32'h0;
            end else begin
                e_rdata = model_mem[a[9:0]];
            end
        end
    endtask

    task automatic apply_reset();
        srst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 srst_n = 1'b1;
        model_reset();
    endtask

    // Drive one request pattern and observe the whole transaction; starts and ends just after a rising edge.
    task automatic txn(input logic v0, input logic we0, input logic [15:0] a0, input logic [31:0] d0,
                       input logic v1, input logic we1, input logic [15:0] a1, input logic [31:0] d1,
                       input int hold, output obs_t o);
        int n;
        logic win, v;
        o = '0;
        o.stable = 1'b1;
        req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
        rsp0_ready = (hold == 0); rsp1_ready = (hold == 0);
        n = 0;
        @(negedge clk);
        while (!(req0_ready || req1_ready) && n < 20) begin @(negedge clk); n++; end
        if (!(req0_ready || req1_ready)) begin
            o.tmo = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
            return;
        end
        o.rdy = {req1_ready, req0_ready};
        o.acc_we = mem_we; o.acc_addr = mem_addr; o.acc_wdata = mem_wdata;
        win = req1_ready;
        @(posedge clk); #1;
        // Both ports keep requesting with altered payloads; nothing may be accepted meanwhile.
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = a0 ^ 16'h0003; req0_wdata = ~d0;
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = a1 ^ 16'h0005; req1_wdata = ~d1;
        n = 0; v = 1'b0;
        while (!v && n < 20) begin
            @(negedge clk); n++;
            v = win ? rsp1_valid : rsp0_valid;
            if (mem_we || req0_ready || req1_ready || (win ? rsp0_valid : rsp1_valid)) o.stray = 1'b1;
        end
        if (!v) begin
            o.tmo = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
            rsp0_ready = 1'b1; rsp1_ready = 1'b1;
            return;
        end
        o.lat = 8'(n);
        o.rdata = win ? rsp1_rdata : rsp0_rdata;
        o.err = win ? rsp1_err : rsp0_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (i == hold - 1) begin rsp0_ready = 1'b1; rsp1_ready = 1'b1; end
            @(negedge clk);
            if (!(win ? rsp1_valid : rsp0_valid) || (win ? rsp1_rdata : rsp0_rdata) !== o.rdata ||
                (win ? rsp1_err : rsp0_err) !== o.err) o.stable = 1'b0;
            if (mem_we || req0_ready || req1_ready) o.stray = 1'b1;
        end
        @(posedge clk); #1;
        o.cleared = !rsp0_valid && !rsp1_valid;
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_reset();
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 16'd3; req0_wdata = 32'h1234_5678;
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 16'd4; req1_wdata = 32'h8765_4321;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        srst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        vectors++; if ({req1_ready, req0_ready} !== 2'b00) begin miscompares++; $display("FAIL reset_ready got=%b want=00", {req1_ready, req0_ready}); end
        vectors++; if ({rsp1_valid, rsp0_valid} !== 2'b00) begin miscompares++; $display("FAIL reset_rsp_valid got=%b want=00", {rsp1_valid, rsp0_valid}); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_mem_we got=%b want=0", mem_we); end
        vectors++; if (mem_addr !== 16'h0) begin miscompares++; $display("FAIL reset_mem_addr got=%h want=0000", mem_addr); end
        vectors++; if (mem_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_mem_wdata got=%h want=0", mem_wdata); end
        vectors++; if (mem_srst !== 1'b1) begin miscompares++; $display("FAIL reset_mem_srst got=%b want=1", mem_srst); end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0; srst_n = 1'b1;
        model_reset();
        @(negedge clk);
        vectors++; if (mem_srst !== 1'b0) begin miscompares++; $display("FAIL run_mem_srst got=%b want=0", mem_srst); end
        @(posedge clk); #1;
    endtask

    task automatic test_unwritten();
        obs_t o;
        logic [1:0] er; logic ew, ee; logic [15:0] ea; logic [31:0] ed, erd;
        model_txn(1'b1, 1'b0, 16'd7, 32'h0, 1'b0, 1'b0, 16'd0, 32'h0, er, ew, ea, ed, erd, ee);
        txn(1'b1, 1'b0, 16'd7, 32'h0, 1'b0, 1'b0, 16'd0, 32'h0, 0, o);
        vectors++; if (o.tmo !== 1'b0) begin miscompares++; $display("FAIL unwritten_timeout got=%b want=0", o.tmo); end
        vectors++; if (o.rdata !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL unwritten_rdata got=%h want=ffffffff", o.rdata); end
    endtask

    task automatic test_write_read();
        obs_t o;
        logic [1:0] er; logic ew, ee; logic [15:0] ea; logic [31:0] ed, erd;
        model_txn(1'b1, 1'b1, 16'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, 16'd0, 32'h0, er, ew, ea, ed, erd, ee);
        txn(1'b1, 1'b1, 16'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, 16'd0, 32'h0, 0, o);
        vectors++; if (o.rdy !== 2'b01) begin miscompares++; $display("FAIL wr_ready got=%b want=01", o.rdy); end
        vectors++; if (o.acc_we !== 1'b1 || o.acc_addr !== 16'd5 || o.acc_wdata !== 32'hDEAD_BEEF) begin
            miscompares++; $display("FAIL wr_mem_cmd got=%b/%h/%h want=1/0005/deadbeef", o.acc_we, o.acc_addr, o.acc_wdata); end
        vectors++; if (o.rdata !== 32'h0 || o.err !== 1'b0) begin miscompares++; $display("FAIL wr_rsp got=%h/%b want=0/0", o.rdata, o.err); end
        model_txn(1'b1, 1'b0, 16'd5, 32'h0, 1'b0, 1'b0, 16'd0, 32'h0, er, ew, ea, ed, erd, ee);
        txn(1'b1, 1'b0, 16'd5, 32'h0, 1'b0, 1'b0, 16'd0, 32'h0, 0, o);
        vectors++; if (o.acc_we !== 1'b0) begin miscompares++; $display("FAIL rd_mem_we got=%b want=0", o.acc_we); end
        vectors++; if (o.rdata !== 32'hDEAD_BEEF || o.err !== 1'b0) begin miscompares++; $display("FAIL rd_rsp got=%h/%b want=deadbeef/0", o.rdata, o.err); end
        vectors++; if (o.lat !== 8'd2) begin miscompares++; $display("FAIL rd_latency got=%0d want=2", o.lat); end
        vectors++; if (o.cleared !== 1'b1) begin miscompares++; $display("FAIL rd_idle_after got=%b want=1", o.cleared); end
    endtask

    task automatic test_round_robin();
        obs_t o;
        logic [1:0] er; logic ew, ee; logic [15:0] ea; logic [31:0] ed, erd;
        model_txn(1'b1, 1'b1, 16'd1, 32'h1111_0001, 1'b0, 1'b0, 16'd0, 32'h0, er, ew, ea, ed, erd, ee);
        txn(1'b1, 1'b1, 16'd1, 32'h1111_0001, 1'b0, 1'b0, 16'd0, 32'h0, 0, o);
        model_txn(1'b0, 1'b0, 16'd0, 32'h0, 1'b1, 1'b1, 16'd2, 32'h2222_0002, er, ew, ea, ed, erd, ee);
        txn(1'b0, 1'b0, 16'd0, 32'h0, 1'b1, 1'b1, 16'd2, 32'h2222_0002, 0, o);
        vectors++; if (o.rdy !== 2'b10) begin miscompares++; $display("FAIL single_port1_ready got=%b want=10", o.rdy); end
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 16'd1;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 16'd2;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            model_txn(1'b1, 1'b0, 16'd1, 32'h0, 1'b1, 1'b0, 16'd2, 32'h0, er, ew, ea, ed, erd, ee);
            txn(1'b1, 1'b0, 16'd1, 32'h0, 1'b1, 1'b0, 16'd2, 32'h0, 0, o);
            vectors++; if (o.rdy !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                miscompares++; $display("FAIL rr_grant k=%0d got=%b want=%b", k, o.rdy, (k % 2 == 0) ? 2'b01 : 2'b10); end
            vectors++; if (o.rdata !== ((k % 2 == 0) ? 32'h1111_0001 : 32'h2222_0002)) begin
                miscompares++; $display("FAIL rr_rdata k=%0d got=%h", k, o.rdata); end
        end
    endtask

    task automatic test_error();
        obs_t o;
        logic [1:0] er; logic ew, ee; logic [15:0] ea; logic [31:0] ed, erd;
        model_txn(1'b0, 1'b0, 16'd0, 32'h0, 1'b1, 1'b0, 16'd1024, 32'h0, er, ew, ea, ed, erd, ee);
        txn(1'b0, 1'b0, 16'd0, 32'h0, 1'b1, 1'b0, 16'd1024, 32'h0, 0, o);
        vectors++; if (o.acc_we !== 1'b0 || o.stray !== 1'b0) begin miscompares++; $display("FAIL err_mem_we got=%b stray=%b want=0/0", o.acc_we, o.stray); end
        vectors++; if (o.err !== 1'b1 || o.rdata !== 32'h0) begin miscompares++; $display("FAIL err_rsp got=%b/%h want=1/0", o.err, o.rdata); end
        vectors++; if (o.acc_addr !== ea) begin miscompares++; $display("FAIL err_mem_addr_hold got=%h want=%h", o.acc_addr, ea); end
        // Out-of-range write must not alias onto a real location either.
        model_txn(1'b0, 1'b0, 16'd0, 32'h0, 1'b1, 1'b1, 16'd1025, 32'h5555_AAAA, er, ew, ea, ed, erd, ee);
        txn(1'b0, 1'b0, 16'd0, 32'h0, 1'b1, 1'b1, 16'd1025, 32'h5555_AAAA, 0, o);
        vectors++; if (o.acc_we !== 1'b0 || o.err !== 1'b1) begin miscompares++; $display("FAIL err_write got=we%b/err%b want=0/1", o.acc_we, o.err); end
        model_txn(1'b0, 1'b0, 16'd0, 32'h0, 1'b1, 1'b0, 16'd1, 32'h0, er, ew, ea, ed, erd, ee);
        txn(1'b0, 1'b0, 16'd0, 32'h0, 1'b1, 1'b0, 16'd1, 32'h0, 0, o);
        vectors++; if (o.err !== 1'b0 || o.rdata !== 32'h1111_0001) begin miscompares++; $display("FAIL err_recover got=%b/%h want=0/11110001", o.err, o.rdata); end
    endtask

    task automatic test_backpressure();
        obs_t o;
        logic [1:0] er; logic ew, ee; logic [15:0] ea; logic [31:0] ed, erd;
        model_txn(1'b1, 1'b0, 16'd5, 32'h0, 1'b0, 1'b0, 16'd0, 32'h0, er, ew, ea, ed, erd, ee);
        txn(1'b1, 1'b0, 16'd5, 32'h0, 1'b0, 1'b0, 16'd0, 32'h0, 5, o);
        vectors++; if (o.stable !== 1'b1) begin miscompares++; $display("FAIL bp_stable got=%b want=1", o.stable); end
        vectors++; if (o.stray !== 1'b0) begin miscompares++; $display("FAIL bp_no_accept got=%b want=0", o.stray); end
        vectors++; if (o.rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL bp_rdata got=%h want=deadbeef", o.rdata); end
        vectors++; if (o.cleared !== 1'b1) begin miscompares++; $display("FAIL bp_idle got=%b want=1", o.cleared); end
    endtask

    task automatic test_reset_in_resp();
        obs_t o;
        int n;
        logic [1:0] er; logic ew, ee; logic [15:0] ea; logic [31:0] ed, erd;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 16'd1; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!req0_ready && n < 20) begin @(negedge clk); n++; end
        vectors++; if (req0_ready !== 1'b1) begin miscompares++; $display("FAIL rstresp_accept got=%b want=1", req0_ready); end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        vectors++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'h1111_0001) begin
            miscompares++; $display("FAIL rstresp_pending got=%b/%h want=1/11110001", rsp0_valid, rsp0_rdata); end
        @(posedge clk); #1 srst_n = 1'b0;
        @(posedge clk); #1 srst_n = 1'b1;
        model_reset();
        vectors++; if ({rsp1_valid, rsp0_valid} !== 2'b00 || rsp0_rdata !== 32'h0) begin
            miscompares++; $display("FAIL rstresp_dropped got=%b/%h want=00/0", {rsp1_valid, rsp0_valid}, rsp0_rdata); end
        model_txn(1'b1, 1'b0, 16'd1, 32'h0, 1'b1, 1'b0, 16'd2, 32'h0, er, ew, ea, ed, erd, ee);
        txn(1'b1, 1'b0, 16'd1, 32'h0, 1'b1, 1'b0, 16'd2, 32'h0, 0, o);
        vectors++; if (o.rdy !== 2'b01) begin miscompares++; $display("FAIL rstresp_first_tie got=%b want=01", o.rdy); end
    endtask

    function automatic logic [15:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 16'(1024 + $urandom_range(0, 64511));
        return 16'($urandom_range(0, 15));
    endfunction

    task automatic test_random();
        obs_t o;
        logic [1:0] vv, er;
        logic we0, we1, ew, ee;
        logic [15:0] a0, a1, ea;
        logic [31:0] d0, d1, ed, erd;
        int hold;
        for (int k = 0; k < 60; k++) begin
            vv = 2'($urandom_range(1, 3));
            we0 = 1'($urandom_range(0, 1)); a0 = rand_addr(); d0 = $urandom;
            we1 = 1'($urandom_range(0, 1)); a1 = rand_addr(); d1 = $urandom;
            hold = $urandom_range(0, 2);
            model_txn(vv[0], we0, a0, d0, vv[1], we1, a1, d1, er, ew, ea, ed, erd, ee);
            txn(vv[0], we0, a0, d0, vv[1], we1, a1, d1, hold, o);
            vectors++; if (o.tmo !== 1'b0) begin miscompares++; $display("FAIL rnd_timeout k=%0d", k); end
            vectors++; if (o.rdy !== er) begin miscompares++; $display("FAIL rnd_grant k=%0d got=%b want=%b", k, o.rdy, er); end
            vectors++; if (o.acc_we !== ew || o.acc_addr !== ea) begin
                miscompares++; $display("FAIL rnd_mem_cmd k=%0d got=%b/%h want=%b/%h", k, o.acc_we, o.acc_addr, ew, ea); end
            if (!ee) begin
                vectors++; if (o.acc_wdata !== ed) begin miscompares++; $display("FAIL rnd_mem_wdata k=%0d got=%h want=%h", k, o.acc_wdata, ed); end
            end
            vectors++; if (o.rdata !== erd || o.err !== ee) begin
                miscompares++; $display("FAIL rnd_rsp k=%0d got=%h/%b want=%h/%b", k, o.rdata, o.err, erd, ee); end
            vectors++; if (o.lat !== 8'd2) begin miscompares++; $display("FAIL rnd_latency k=%0d got=%0d want=2", k, o.lat); end
            vectors++; if (o.stable !== 1'b1 || o.stray !== 1'b0 || o.cleared !== 1'b1) begin
                miscompares++; $display("FAIL rnd_protocol k=%0d stable=%b stray=%b cleared=%b want=1/0/1", k, o.stable, o.stray, o.cleared); end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) model_mem[i] = 32'hFFFF_FFFF;
        model_reset();
        srst_n = 1'b0;
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = 16'h0; req0_wdata = 32'h0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = 16'h0; req1_wdata = 32'h0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        test_reset();
        test_unwritten();
        test_write_read();
        test_round_robin();
        test_error();
        test_backpressure();
        test_reset_in_resp();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=expired want=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 16, word-address width.
REQ-002 The module SHALL have parameter DATA_W, default 32, data width.
REQ-003 The module SHALL have parameter DEPTH, default 1024, number of valid memory words.
REQ-004 The module SHALL use one clock and a synchronous, active-low reset; the reset port is clk_i-sampled srst_ni.
REQ-005 Ports (name, direction, width, meaning):
  clk_i  in  1  clock, all state on rising edge
  srst_ni  in  1  synchronous active-low reset
  reqK_valid_i  in  1  port K (K=0,1) request valid
  reqK_ready_o  out  1  port K request accepted this cycle
  reqK_we_i  in  1  1=write, 0=read
  reqK_addr_i  in  ADDR_W  word address
  reqK_wdata_i  in  DATA_W  write data
  rspK_valid_o  out  1  port K response valid
  rspK_ready_i  in  1  port K response consumed
  rspK_rdata_o  out  DATA_W  read data (0 for writes/errors)
  rspK_err_o  out  1  address out of range
  mem_we_o  out  1  memory write enable
  mem_addr_o  out  ADDR_W  memory address
  mem_wdata_o  out  DATA_W  memory write data
  mem_srst_o  out  1  memory read-port reset, active-high
  mem_rdata_i  in  DATA_W  memory read data, valid one cycle after read issue

Function
REQ-006 The FSM SHALL have states IDLE, BUSY, RESP; exactly one transaction outstanding at a time.
REQ-007 IDLE: if any reqK_valid_i high, the winner's reqK_ready_o SHALL be 1 combinationally; loser's ready 0; accept = valid & ready; next state BUSY.
REQ-008 Arbitration SHALL be round-robin: single requester wins; on tie, winner is the port not granted last; last-grant register resets to 1 (port 0 wins first tie).
REQ-009 On accept with addr < DEPTH, mem_addr_o/mem_wdata_o SHALL carry the winner's addr/wdata and mem_we_o = winner's we, in the same cycle.
REQ-010 On accept with addr >= DEPTH, mem_we_o SHALL stay 0 (no memory write), and the response SHALL carry err=1, rdata=0.
REQ-011 Outside an accept cycle mem_we_o SHALL be 0; mem_addr_o SHALL hold last issued address.
REQ-012 BUSY (one cycle): response register SHALL capture mem_rdata_i for an in-range read, 0 for write or error; next state RESP.
REQ-013 RESP: rspK_valid_o SHALL be 1 only for the granted port, rdata/err stable until rspK_ready_i=1; then next state IDLE.
REQ-014 reqK_ready_o SHALL be 0 in BUSY and RESP; minimum transaction period is 3 cycles (accept, BUSY, RESP with ready=1).
REQ-015 rspK_rdata_o and rspK_err_o SHALL be 0 whenever rspK_valid_o is 0.
REQ-016 mem_srst_o SHALL equal ~srst_ni.
REQ-017 Requester changing addr/data while valid and not ready SHALL be tolerated; only values at the accept cycle are used.

Reset
REQ-018 srst_ni=0 at a rising edge SHALL force state IDLE, last-grant=1, response register 0, all rsp*_valid_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0 from the next cycle.
REQ-019 Reset in BUSY or RESP SHALL drop the outstanding response without emission; an in-flight write already issued is not undone.
REQ-020 During reset all reqK_ready_o SHALL be 0.

Verification
REQ-021 Port 0 write addr 5, data 0xDEADBEEF, then read addr 5 -> write resp rdata=0 err=0; read resp rdata=0xDEADBEEF, 2 cycles after accept.
REQ-022 Both ports valid continuously from reset, reads addr 1 and 2 -> grants alternate 0,1,0,1; each port receives its own data.
REQ-023 Port 1 read addr 1024 -> mem_we_o never 1, rsp1 err=1 rdata=0; following in-range read returns correct data.
REQ-024 rsp0_ready_i held 0 for 5 cycles in RESP -> rsp0_valid_o and rdata stable all 5 cycles, no new accept; ready=1 -> IDLE next cycle.
REQ-025 srst_ni=0 during RESP -> rsp valid 0 next cycle, state IDLE; after release, port 0 wins first tie.
REQ-026 Read of unwritten addr 7 after memory init -> rdata=0xFFFFFFFF.
